// File: rtl/hex_display_scanner.sv
// Scans a multi-digit hex value across one shared 7-segment decoder.
// New values are staged and only applied at frame boundaries so frames never tear.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DPIn,
  input  logic                    BlankLZ,
  input  logic                    Enable,
  output logic [3:0]              Hex,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   DigitEn_n,
  output logic                    FrameStart,
  output logic                    Pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] stg_val;
  logic [NUM_DIGITS-1:0][3:0] disp_val;
  logic [NUM_DIGITS-1:0]      stg_dp;
  logic [NUM_DIGITS-1:0]      disp_dp;

  logic                  slot_end;
  logic                  boundary;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_blank;

  assign slot_end = Enable && (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  // Walk from the top digit down; a digit is blank while everything above is zero.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_val[i] == 4'h0);
      blank[i] = BlankLZ && (i != 0) && zero_run && !disp_dp[i];
    end
  end

  always_comb begin
    sel       = '0;
    sel[idx]  = 1'b1;
    cur_hex   = disp_val[idx];
    cur_dp    = disp_dp[idx];
    cur_blank = blank[idx];
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else if (Enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Transfer reads the old staging value before a same-cycle Load overwrites it.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      stg_val  <= '0;
      stg_dp   <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      Pending  <= 1'b0;
    end else begin
      if (boundary && Pending) begin
        disp_val <= stg_val;
        disp_dp  <= stg_dp;
        Pending  <= Load;
      end
      if (Load) begin
        stg_val <= Value;
        stg_dp  <= DPIn;
        Pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Hex        <= 4'h0;
      DP         <= 1'b0;
      DigitEn_n  <= '1;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= boundary;
      if (!Enable) begin
        DigitEn_n <= '1;
      end else if (cur_blank) begin
        DigitEn_n <= '1;
        Hex       <= 4'h0;
        DP        <= 1'b0;
      end else begin
        DigitEn_n <= ~sel;
        Hex       <= cur_hex;
        DP        <= cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: slot-level reference model feeds a queue,
// a negedge monitor pops and compares against the scanner outputs.
module tb_hex_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic          Load = 1'b0;
  logic [15:0]   Value = '0;
  logic [3:0]    DPIn = '0;
  logic          BlankLZ = 1'b0;
  logic          Enable = 1'b1;
  logic [3:0]    Hex;
  logic          DP;
  logic [3:0]    DigitEn_n;
  logic          FrameStart;
  logic          Pending;

  typedef struct packed {
    logic [3:0] hex;
    logic       dp;
    logic [3:0] en;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_tick = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_stg  = '0;
  logic [3:0]  m_ddp  = '0;
  logic [3:0]  m_sdp  = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_hex  = '0;
  logic        m_dp   = 1'b0;

  hex_display_scanner #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Load      (Load),
    .Value     (Value),
    .DPIn      (DPIn),
    .BlankLZ   (BlankLZ),
    .Enable    (Enable),
    .Hex       (Hex),
    .DP        (DP),
    .DigitEn_n (DigitEn_n),
    .FrameStart(FrameStart),
    .Pending   (Pending)
  );

  initial forever #5 Clk = ~Clk;

  // Reference: position in the frame is one integer, digit = tick / DIV.
  initial begin
    int   d;
    logic bl;
    logic bnd;
    exp_t e;
    forever begin
      @(posedge Clk or negedge nReset);
      if (!nReset) begin
        m_tick = 0;
        m_disp = '0;
        m_stg  = '0;
        m_ddp  = '0;
        m_sdp  = '0;
        m_pend = 1'b0;
        m_hex  = '0;
        m_dp   = 1'b0;
      end else begin
        d   = m_tick / DIV;
        bnd = 1'b0;
        e.en = 4'hF;
        e.fs = 1'b0;
        if (Enable) begin
          bl = BlankLZ && (d > 0) && ((m_disp >> (4 * d)) == 0)
               && !m_ddp[d];
          e.en  = bl ? 4'hF : ~(4'(1) << d);
          m_hex = bl ? 4'h0 : 4'((m_disp >> (4 * d)) & 16'hF);
          m_dp  = bl ? 1'b0 : m_ddp[d];
          bnd   = (m_tick == FR - 1);
          e.fs  = bnd;
          m_tick = (m_tick + 1) % FR;
        end
        if (bnd && m_pend) begin
          m_disp = m_stg;
          m_ddp  = m_sdp;
          m_pend = 1'b0;
        end
        if (Load) begin
          m_stg  = Value;
          m_sdp  = DPIn;
          m_pend = 1'b1;
        end
        e.hex  = m_hex;
        e.dp   = m_dp;
        e.pend = m_pend;
        q.push_back(e);
      end
    end
  end

  function automatic exp_t sample();
    return {Hex, DP, DigitEn_n, FrameStart, Pending};
  endfunction

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge Clk);
      g = sample();
      if (!nReset) begin
        q.delete();
        n_checks++;
        if (g != exp_t'({4'h0, 1'b0, 4'hF, 1'b0, 1'b0})) begin
          n_fail++;
          $display("FAIL reset_state got=%h want=%h", g,
                   exp_t'({4'h0, 1'b0, 4'hF, 1'b0, 1'b0}));
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (g != e) begin
          n_fail++;
          $display("FAIL scan t=%0t got hex=%h dp=%b en=%b fs=%b pend=%b want hex=%h dp=%b en=%b fs=%b pend=%b",
                   $time, g.hex, g.dp, g.en, g.fs, g.pend,
                   e.hex, e.dp, e.en, e.fs, e.pend);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    Value = v;
    DPIn  = d;
    Load  = 1'b1;
    step(1);
    Load  = 1'b0;
  endtask

  task automatic wait_tick(input int t, input string name);
    int k;
    k = 0;
    while (m_tick != t && k < 200) begin
      step(1);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL %s timeout tick=%0d want=%0d", name, m_tick, t);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    step(40);

    step(5);
    load(16'hA3F0, 4'b0010);
    step(40);

    load(16'h1111, 4'b0000);
    wait_tick(FR - 1, "boundary_wait");
    load(16'h2222, 4'b0000);
    step(40);

    BlankLZ = 1'b1;
    load(16'h0005, 4'b0000);
    step(40);
    load(16'h0005, 4'b0100);
    step(40);
    BlankLZ = 1'b0;

    wait_tick(2 * DIV + 1, "digit2_wait");
    Enable = 1'b0;
    step(10);
    Enable = 1'b1;
    step(20);

    load(16'hBEEF, 4'b0001);
    step(2);
    @(posedge Clk);
    #3 nReset = 1'b0;
    #1;
    chk("async_en", 16'(DigitEn_n), 16'hF);
    chk("async_hex", 16'(Hex), 16'h0);
    chk("async_dp", 16'(DP), 16'h0);
    chk("async_fs", 16'(FrameStart), 16'h0);
    chk("async_pend", 16'(Pending), 16'h0);
    step(3);
    nReset = 1'b1;
    step(40);

    for (int i = 0; i < 400; i++) begin
      Load   = ($urandom % 8) == 0;
      Value  = 16'($urandom);
      DPIn   = 4'($urandom);
      if (($urandom % 32) == 0) BlankLZ = ~BlankLZ;
      Enable = ($urandom % 10) != 0;
      step(1);
    end
    Load   = 1'b0;
    Enable = 1'b1;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
